seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised multi-cycle integer divider for the datapath's DIV/DIVU path, producing quotient and remainder with a start/finished handshake. It generalises the fixed 32-bit signed divider in three ways: operand width is a parameter, a per-operation signed/unsigned mode input is added, and the block reports busy, divide-by-zero and signed-overflow status. It uses restoring division on operand magnitudes, one quotient bit per cycle, followed by sign fix-up.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; sampled on rising edge of clock
- div_start  input  1  request; sampled only when busy = 0
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with div_start
- dividend  input  WIDTH  captured with div_start
- divisor  input  WIDTH  captured with div_start
- busy  output  1  operation in progress; start ignored while high
- finished  output  1  one-cycle pulse; results valid from this cycle on
- div_zero  output  1  last accepted operation had divisor = 0
- overflow  output  1  last accepted operation was signed MIN / -1
- quotient  output  WIDTH  registered result, held until next completion
- remainder  output  WIDTH  registered result, held until next completion

## Operation
- States: IDLE, ITER, FIX, DONE. Reset (reset = 0 at an edge) forces IDLE and clears all outputs and internal registers to 0, including mid-operation; the operation in flight is discarded.
- Acceptance: an edge with div_start = 1 in IDLE or DONE captures the operands and mode.
  - If divisor = 0, the next state is DONE.
  - Otherwise the next state is ITER with count = 0. The block loads the magnitudes |dividend| and |divisor| (two's-complement negation when is_signed and MSB = 1, else the raw value), clears the partial remainder, and latches the quotient sign (dividend MSB xor divisor MSB) and remainder sign (dividend MSB), both gated by is_signed.
- ITER, each edge:
  - Shift {partial remainder (WIDTH+1 bits), quotient register} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient LSB to 1; else restore.
  - Increment count. After WIDTH iterations, go to FIX.
- FIX edge:
  - quotient output = quotient sign ? −q : q; remainder output = remainder sign ? −r : r. Truncation is toward zero, and the remainder takes the sign of the dividend.
  - Set overflow = is_signed & dividend = MIN & divisor = all-ones; div_zero = 0. Go to DONE.
  - The MIN / −1 case needs no special datapath: it yields quotient = MIN, remainder = 0, with overflow set.
- Divide-by-zero (taken from IDLE/DONE, entering DONE directly): quotient = all-ones, remainder = dividend as captured, div_zero = 1, overflow = 0.
- DONE: finished = 1 for this cycle only. Next state is IDLE, unless div_start = 1, which starts a new operation back-to-back.
- busy = 1 in ITER and FIX; 0 in IDLE and DONE.
- Results, div_zero and overflow hold their values until the next completion or reset.
- Counter width is $clog2(WIDTH+1). All arithmetic is unsigned on magnitudes. Negation wraps modulo 2^WIDTH.

## Timing
- Start accepted at edge E0.
- Normal path:
  - busy rises after E0. Iterations occur at edges E1..E_WIDTH.
  - FIX at E_(WIDTH+1) registers the results; finished and results are visible after E_(WIDTH+1).
  - busy falls after E_(WIDTH+1). finished falls after E_(WIDTH+2), unless a new start re-enters.
  - Latency is WIDTH+1 cycles from start to finished (33 for WIDTH = 32).
- Divide-by-zero path: finished and div_zero are visible after E1 (latency 1); busy never rises.
- div_start held high continuously: a new operation is accepted in each DONE cycle.
- div_start high while busy has no effect. Operand changes while busy have no effect.
- Reset low coincident with div_start: reset wins, and nothing is accepted.

## Test plan
- WIDTH = 32, unsigned 7 / 2 with start pulsed one cycle → finished exactly 33 cycles later; q = 3, r = 1; busy high for 33 cycles.
- Signed: 15 / −4 → q = −3, r = 3. −10 / 3 → q = −3, r = −1. −12 / −4 → q = 3, r = 0. 5 / 70 → q = 0, r = 5. 13 / 5 → q = 2, r = 3. Run all back-to-back with start held high, one completion every 33 cycles.
- 1 / 0 (signed) → after 1 cycle: finished = 1, div_zero = 1, q = 0xFFFFFFFF, r = 1, busy stays 0. Following 13 / 5 → div_zero clears, q = 2, r = 3.
- Signed 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0, overflow = 1. Unsigned 0xFFFFFFFF / 2 → q = 0x7FFFFFFF, r = 1, overflow = 0.
- Start 100 / 7, pulse div_start again with 9 / 3 at cycle 10 → ignored; q = 14, r = 2. Separately, assert reset low at cycle 20 of an operation → all outputs 0 next cycle, no finished; then 9 / 3 completes normally with q = 3, r = 0.
- WIDTH = 8, signed −128 / 3 → q = −42 (0xD6), r = −2 (0xFE), latency 9; unsigned 200 / 7 → q = 28, r = 4.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed/unsigned, with div-by-zero and overflow status
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             finished,
    output logic             div_zero,
    output logic             overflow,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_r, quo_r, dvs_m, a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             q_neg, r_neg, ovf_r, a_neg, b_neg, accept, last;

    always_comb begin
        a_neg     = is_signed & dividend[WIDTH-1];
        b_neg     = is_signed & divisor[WIDTH-1];
        a_mag     = a_neg ? -dividend : dividend;
        b_mag     = b_neg ? -divisor : divisor;
        accept    = div_start & (state == IDLE | state == DONE);
        last      = count == CW'(WIDTH - 1);
        shifted   = {rem_r, quo_r[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_m};
        state_nxt = accept ? ((divisor == '0) ? DONE : ITER) :
                    (state == ITER) ? (last ? FIX : ITER) :
                    (state == FIX) ? DONE : IDLE;
        busy      = state == ITER | state == FIX;
        finished  = state == DONE;
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_m     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
                overflow  <= 1'b0;
            end else begin
                count <= '0;
                rem_r <= '0;
                quo_r <= a_mag;
                dvs_m <= b_mag;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
                ovf_r <= is_signed & (dividend == MIN) & (divisor == '1);
            end
        end else if (state == ITER) begin
            count <= count + 1'b1;
            rem_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
        end else if (state == FIX) begin
            quotient  <= q_neg ? -quo_r : quo_r;
            remainder <= r_neg ? -rem_r : rem_r;
            overflow  <= ovf_r;
            div_zero  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH 32 and WIDTH 8 instances)
module tb_seq_divider;
    localparam int W = 32;

    logic         clock = 1'b0, reset = 1'b0;
    logic         div_start = 1'b0, is_signed = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic         busy, finished, div_zero, overflow;
    logic [W-1:0] quotient, remainder;

    logic         st8 = 1'b0, sg8 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0;
    logic         busy8, fin8, dz8, ov8;
    logic [7:0]   q8, r8;

    seq_divider #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .div_start(div_start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .finished(finished),
        .div_zero(div_zero), .overflow(overflow), .quotient(quotient), .remainder(remainder)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .div_start(st8), .is_signed(sg8),
        .dividend(a8), .divisor(b8), .busy(busy8), .finished(fin8),
        .div_zero(dz8), .overflow(ov8), .quotient(q8), .remainder(r8)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           fin;
    } exp_t;

    typedef struct {
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    int   checks = 0, errors = 0, cyc = 0;
    exp_t sb[$];
    exp_t e_m;
    op_t  ops[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (finished) begin
            if (sb.size() == 0) begin
                chk("unexpected_finish", {31'b0, finished}, '0);
            end else begin
                e_m = sb.pop_front();
                chk("quotient", quotient, e_m.q);
                chk("remainder", remainder, e_m.r);
                chk("div_zero", {31'b0, div_zero}, {31'b0, e_m.dz});
                chk("overflow", {31'b0, overflow}, {31'b0, e_m.ov});
                chk("latency", cyc, e_m.fin);
                chk("busy_at_finish", {31'b0, busy}, '0);
            end
        end
    end

    task automatic push(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.fin = cyc + 1;
        end else begin
            e.fin = cyc + W + 2;
            if (s && a == 32'h8000_0000 && b == '1) begin
                e.q  = a;
                e.r  = '0;
                e.ov = 1'b1;
            end else if (s) begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        sb.push_back(e);
    endtask

    task automatic launch(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
        @(negedge clock);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        if (expect_done) push(s, a, b);
    endtask

    task automatic wait_fin;
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!finished && n < 200);
        if (!finished) chk("finish_timeout", {31'b0, finished}, 32'd1);
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), '0);
    endtask

    task automatic op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        launch(s, a, b, 1'b1);
        @(negedge clock);
        div_start = 1'b0;
        drain();
    endtask

    task automatic add(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        op_t o;
        o.s = s;
        o.a = a;
        o.b = b;
        ops.push_back(o);
    endtask

    task automatic b2b;
        launch(ops[0].s, ops[0].a, ops[0].b, 1'b1);
        for (int i = 1; i < ops.size(); i++) begin
            wait_fin();
            is_signed = ops[i].s;
            dividend  = ops[i].a;
            divisor   = ops[i].b;
            push(ops[i].s, ops[i].a, ops[i].b);
        end
        wait_fin();
        div_start = 1'b0;
        drain();
        ops.delete();
    endtask

    task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er);
        int n = 0;
        @(negedge clock);
        sg8 = s;
        a8  = a;
        b8  = b;
        st8 = 1'b1;
        do begin
            @(negedge clock);
            st8 = 1'b0;
            n++;
        end while (!fin8 && n < 50);
        chk("lat8", n - 1, 32'd9);
        chk("q8", {24'b0, q8}, {24'b0, eq});
        chk("r8", {24'b0, r8}, {24'b0, er});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int bc;
        repeat (3) @(negedge clock);
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        chk("rst_busy", {31'b0, busy}, '0);
        chk("rst_finished", {31'b0, finished}, '0);
        chk("rst_div_zero", {31'b0, div_zero}, '0);
        chk("rst_overflow", {31'b0, overflow}, '0);
        reset = 1'b1;

        bc = 0;
        launch(1'b0, 32'd7, 32'd2, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            div_start = 1'b0;
            if (busy) bc++;
        end
        chk("busy_cycles", bc, 32'd33);
        drain();

        add(1'b1, 32'd15, -32'sd4);
        add(1'b1, -32'sd10, 32'd3);
        add(1'b1, -32'sd12, -32'sd4);
        add(1'b1, 32'd5, 32'd70);
        add(1'b1, 32'd13, 32'd5);
        b2b();

        launch(1'b1, 32'd1, 32'd0, 1'b1);
        @(negedge clock);
        div_start = 1'b0;
        chk("dz_busy", {31'b0, busy}, '0);
        drain();
        op(1'b1, 32'd13, 32'd5);

        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        op(1'b0, 32'hFFFF_FFFF, 32'd2);

        launch(1'b0, 32'd100, 32'd7, 1'b1);
        @(negedge clock);
        div_start = 1'b0;
        repeat (9) @(negedge clock);
        dividend  = 32'd9;
        divisor   = 32'd3;
        div_start = 1'b1;
        @(negedge clock);
        div_start = 1'b0;
        drain();
        repeat (3) @(negedge clock);

        launch(1'b0, 32'd100, 32'd7, 1'b0);
        @(negedge clock);
        div_start = 1'b0;
        repeat (19) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_quotient", quotient, '0);
        chk("midrst_remainder", remainder, '0);
        chk("midrst_busy", {31'b0, busy}, '0);
        chk("midrst_finished", {31'b0, finished}, '0);
        reset = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
        div_start = 1'b1;
        @(negedge clock);
        reset     = 1'b1;
        div_start = 1'b0;
        chk("rst_start_busy", {31'b0, busy}, '0);
        repeat (5) @(negedge clock);
        chk("rst_start_idle", {31'b0, busy}, '0);
        op(1'b0, 32'd9, 32'd3);

        for (int i = 0; i < 8; i++) begin
            add(i[0], $urandom, (i == 3) ? 32'd0 : (i[1] ? $urandom : $urandom_range(1, 1000)));
        end
        add(1'b1, 32'h8000_0000, 32'd1);
        add(1'b0, 32'd0, 32'd9);
        b2b();

        op8(1'b1, 8'h80, 8'd3, 8'hD6, 8'hFE);
        op8(1'b0, 8'd200, 8'd7, 8'd28, 8'd4);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
